router_ingress_queue: RTL and testbench

ROUTER_INGRESS_QUEUE -- requirements
Module: router_ingress_queue

---
 rtl/router_pkg.sv | 13 +
 rtl/router_ingress_queue_if.sv | 34 +++
 rtl/router_fifo_mem.sv | 28 ++
 rtl/router_ingress_queue.sv | 92 +++++++++
 tb/tb_router_ingress_queue.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared router constants and the destination-port address type.
`default_nettype none

package router_pkg;

   localparam int NUM_PORTS   = 4;
   localparam int PORT_ADDR_W = 2;

   typedef logic [PORT_ADDR_W-1:0] port_addr_t;

endpackage : router_pkg

`default_nettype wire

// File: rtl/router_ingress_queue_if.sv
// Ingress-side and router-side signal bundle of the ingress queue.
`default_nettype none

interface router_ingress_queue_if
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
);

   logic [DATA_WIDTH-1:0]     in_data;
   port_addr_t                in_addr;
   logic                      in_valid;
   logic                      in_ready;
   logic [NUM_PORTS-1:0]      port_busy;
   logic [DATA_WIDTH-1:0]     din;
   logic                      din_en;
   port_addr_t                addr;
   logic [$clog2(DEPTH):0]    count;
   logic [15:0]               stall_cycles;

   modport master (
      output in_data, in_addr, in_valid, port_busy,
      input  in_ready, din, din_en, addr, count, stall_cycles
   );

   modport slave (
      input  in_data, in_addr, in_valid, port_busy,
      output in_ready, din, din_en, addr, count, stall_cycles
   );

endinterface : router_ingress_queue_if

`default_nettype wire

// File: rtl/router_fifo_mem.sv
// Queue storage: synchronous write, asynchronous read, no reset on the array.
`default_nettype none

module router_fifo_mem #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 34
) (
   input  wire logic                     clk,
   input  wire logic                     i_we,
   input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
   input  wire logic [WIDTH-1:0]         i_wdata,
   input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
   output      logic [WIDTH-1:0]         o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : router_fifo_mem

`default_nettype wire

// File: rtl/router_ingress_queue.sv
// ==========================================================================
//  router_ingress_queue : in-order ingress FIFO feeding a 4-port router,
//  with per-destination head-of-line backpressure and a stall counter.
//  Revision: 1.0
// ==========================================================================
`default_nettype none

module router_ingress_queue
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  wire logic              clk,
   input  wire logic              rst,
   router_ingress_queue_if.slave  bus
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_ENT_W = DATA_WIDTH + PORT_ADDR_W;
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_CNT_W-1:0]    r_count;
   logic [15:0]           r_stall;

   logic [c_ENT_W-1:0]    w_head;
   port_addr_t            w_head_addr;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic                  w_in_ready;
   logic                  w_din_en;
   logic                  w_push;
   logic                  w_pop;

   router_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (c_ENT_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata ({bus.in_addr, bus.in_data}),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_head)
   );

   assign w_head_addr = w_head[c_ENT_W-1 -: PORT_ADDR_W];
   assign w_head_data = w_head[DATA_WIDTH-1:0];

   // Readiness depends only on registered occupancy; a pop in the same cycle
   // does not open a slot while full.
   assign w_in_ready = !rst && (r_count < c_FULL);
   assign w_din_en   = (r_count != '0) && !bus.port_busy[w_head_addr];
   assign w_push     = bus.in_valid && w_in_ready;
   assign w_pop      = w_din_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_stall  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if ((r_count != '0) && !w_din_en && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 1'b1;
         end
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.din_en       = w_din_en;
   assign bus.din          = w_din_en ? w_head_data : '0;
   assign bus.addr         = w_din_en ? w_head_addr : '0;
   assign bus.count        = r_count;
   assign bus.stall_cycles = r_stall;

endmodule : router_ingress_queue

`default_nettype wire

// File: tb/tb_router_ingress_queue.sv
// Directed self-checking bench for router_ingress_queue.
`default_nettype none

module tb_router_ingress_queue;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   router_ingress_queue_if #(.DATA_WIDTH(32), .DEPTH(8)) bus ();

   router_ingress_queue #(
      .DATA_WIDTH (32),
      .DEPTH      (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_addr   = '0;
      bus.port_busy = 4'h0;

      // Reset state and single-entry latency
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_din_en",   64'(bus.din_en),   64'd0);
      chk("rst_din",      64'(bus.din),      64'd0);
      chk("rst_addr",     64'(bus.addr),     64'd0);
      chk("rst_count",    64'(bus.count),    64'd0);
      chk("rst_stall",    64'(bus.stall_cycles), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.in_addr  = 2'd2;
      bus.in_data  = 32'hA5A5_0001;
      @(negedge clk);
      chk("lat_din_en", 64'(bus.din_en), 64'd1);
      chk("lat_addr",   64'(bus.addr),   64'd2);
      chk("lat_din",    64'(bus.din),    64'hA5A5_0001);
      chk("lat_count",  64'(bus.count),  64'd1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("lat_count_after_pop", 64'(bus.count), 64'd0);
      chk("lat_din_en_after_pop", 64'(bus.din_en), 64'd0);

      // Fill under full backpressure, overflow attempt, then drain
      do_reset();
      bus.port_busy = 4'hF;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_addr  = 2'(i);
         bus.in_data  = 32'hB000_0000 + 32'(i);
         @(negedge clk);
      end
      bus.in_addr = 2'd0;
      bus.in_data = 32'hDEAD_BEEF;
      chk("full_count",    64'(bus.count),    64'd8);
      chk("full_in_ready", 64'(bus.in_ready), 64'd0);
      chk("full_din_en",   64'(bus.din_en),   64'd0);
      @(negedge clk);
      chk("overflow_count", 64'(bus.count), 64'd8);
      bus.in_valid  = 1'b0;
      bus.port_busy = 4'h0;
      #1;
      chk("full_pop_in_ready", 64'(bus.in_ready), 64'd0);
      for (int i = 0; i < 8; i++) begin
         chk("drain_din_en", 64'(bus.din_en), 64'd1);
         chk("drain_din",    64'(bus.din),    64'hB000_0000 + 64'(i));
         chk("drain_addr",   64'(bus.addr),   64'(i % 4));
         @(negedge clk);
      end
      chk("drain_count", 64'(bus.count), 64'd0);
      chk("drain_din_en_end", 64'(bus.din_en), 64'd0);

      // Head-of-line blocking on port 1 with a port-3 entry behind it
      do_reset();
      bus.port_busy = 4'b0010;
      bus.in_valid  = 1'b1;
      bus.in_addr   = 2'd1;
      bus.in_data   = 32'h0000_0011;
      @(negedge clk);
      bus.in_addr = 2'd3;
      bus.in_data = 32'h0000_0033;
      chk("hol_din_en_c1", 64'(bus.din_en), 64'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("hol_din_en", 64'(bus.din_en), 64'd0);
         @(negedge clk);
      end
      chk("hol_stall", 64'(bus.stall_cycles), 64'd5);
      chk("hol_count", 64'(bus.count), 64'd2);
      bus.port_busy = 4'b0000;
      #1;
      chk("hol_first_en",   64'(bus.din_en), 64'd1);
      chk("hol_first_addr", 64'(bus.addr),   64'd1);
      chk("hol_first_din",  64'(bus.din),    64'h11);
      @(negedge clk);
      chk("hol_second_addr", 64'(bus.addr), 64'd3);
      chk("hol_second_din",  64'(bus.din),  64'h33);
      @(negedge clk);
      chk("hol_count_end", 64'(bus.count), 64'd0);
      chk("hol_stall_end", 64'(bus.stall_cycles), 64'd5);

      // Streaming: one push and one pop per cycle, pointers wrap
      do_reset();
      bus.port_busy = 4'h0;
      bus.in_valid  = 1'b1;
      bus.in_addr   = 2'd0;
      bus.in_data   = 32'd100;
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         chk("stream_count", 64'(bus.count),  64'd1);
         chk("stream_din",   64'(bus.din),    64'd100 + 64'(i));
         chk("stream_en",    64'(bus.din_en), 64'd1);
         if (i == 19) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_data = 32'd101 + 32'(i);
            bus.in_addr = 2'(i + 1);
         end
         @(negedge clk);
      end
      chk("stream_count_end", 64'(bus.count), 64'd0);

      // Asynchronous reset mid-stream discards queued entries
      do_reset();
      bus.port_busy = 4'hF;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_addr  = 2'(i);
         bus.in_data  = 32'hC000_0000 + 32'(i);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("mid_count", 64'(bus.count), 64'd5);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_count",    64'(bus.count),    64'd0);
      chk("async_rst_din_en",   64'(bus.din_en),   64'd0);
      chk("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst           = 1'b0;
      bus.port_busy = 4'h0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stale_din_en", 64'(bus.din_en), 64'd0);
         chk("stale_count",  64'(bus.count),  64'd0);
         @(negedge clk);
      end

      // Long stall saturates the counter
      do_reset();
      bus.port_busy = 4'hF;
      bus.in_valid  = 1'b1;
      bus.in_addr   = 2'd2;
      bus.in_data   = 32'hE000_0000;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (70000) @(negedge clk);
      chk("sat_stall",  64'(bus.stall_cycles), 64'hFFFF);
      chk("sat_count",  64'(bus.count),        64'd1);
      chk("sat_din_en", 64'(bus.din_en),       64'd0);
      @(negedge clk);
      chk("sat_hold", 64'(bus.stall_cycles), 64'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_router_ingress_queue

`default_nettype wire
